// File: rtl/mux2_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | mux2_rr_arbiter                                                          |
// | Two-requester arbiter driving a registered 2:1 mux with valid strobe.    |
// | Optional macro MUX2_ARB_ROUND_ROBIN_EN: round-robin ties and preemption; |
// | undefined gives fixed priority to requester 0.                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mux2_rr_arbiter #(
  parameter int WIDTH     = 2,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_0,
  input  logic             req_1,
  input  logic [WIDTH-1:0] data_0,
  input  logic [WIDTH-1:0] data_1,
  output logic             grant_0,
  output logic             grant_1,
  output logic             selector,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid
);

  localparam int c_cnt_w = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [c_cnt_w-1:0] c_burst_last = c_cnt_w'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_0 = 2'd1,
    S_GRANT_1 = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_burst_cnt;
  logic [c_cnt_w-1:0] w_burst_nxt;
  logic               r_selector;
  logic [WIDTH-1:0]   r_data_out;
  logic               r_out_valid;

  logic w_cur;
  logic w_req_cur;
  logic w_req_oth;
  logic w_xfer;
  logic w_expire;
  logic w_preempt_ok;
  logic w_tie_to_1;

  assign w_cur     = (r_state == S_GRANT_1);
  assign w_req_cur = w_cur ? req_1 : req_0;
  assign w_req_oth = w_cur ? req_0 : req_1;
  assign w_xfer    = ((r_state == S_GRANT_0) && req_0) || ((r_state == S_GRANT_1) && req_1);
  assign w_expire  = (r_burst_cnt == c_burst_last);

`ifdef MUX2_ARB_ROUND_ROBIN_EN
  logic r_last;

  // Reset value 1 makes requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (w_xfer) begin
      r_last <= w_cur;
    end
  end

  assign w_preempt_ok = 1'b1;
  assign w_tie_to_1   = ~r_last;
`else
  // Only requester 0 may cut a burst short.
  assign w_preempt_ok = w_cur;
  assign w_tie_to_1   = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;
    case (r_state)
      S_IDLE: begin
        w_burst_nxt = '0;
        if (req_0 && req_1) begin
          w_state_nxt = w_tie_to_1 ? S_GRANT_1 : S_GRANT_0;
        end else if (req_0) begin
          w_state_nxt = S_GRANT_0;
        end else if (req_1) begin
          w_state_nxt = S_GRANT_1;
        end
      end
      S_GRANT_0, S_GRANT_1: begin
        if (w_req_cur) begin
          if (w_expire && w_req_oth && w_preempt_ok) begin
            w_state_nxt = w_cur ? S_GRANT_0 : S_GRANT_1;
            w_burst_nxt = '0;
          end else begin
            w_burst_nxt = w_expire ? '0 : r_burst_cnt + 1'b1;
          end
        end else begin
          w_state_nxt = w_req_oth ? (w_cur ? S_GRANT_0 : S_GRANT_1) : S_IDLE;
          w_burst_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_burst_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_burst_cnt <= '0;
      r_selector  <= 1'b0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_data_out <= w_cur ? data_1 : data_0;
      end
      // Selector holds its last value through IDLE.
      if (w_state_nxt == S_GRANT_1) begin
        r_selector <= 1'b1;
      end else if (w_state_nxt == S_GRANT_0) begin
        r_selector <= 1'b0;
      end
    end
  end

  assign grant_0   = (r_state == S_GRANT_0);
  assign grant_1   = (r_state == S_GRANT_1);
  assign selector  = r_selector;
  assign data_out  = r_data_out;
  assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_mux2_rr_arbiter                                                       |
// | Directed vector bench for mux2_rr_arbiter (MAX_BURST=4 and =1).          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mux2_rr_arbiter;

  logic       clk;
  logic       reset;
  logic       req_0, req_1;
  logic [1:0] data_0, data_1;
  logic       grant_0, grant_1, selector, out_valid;
  logic [1:0] data_out;

  logic       b_reset;
  logic       b_req_0, b_req_1;
  logic [1:0] b_data_0, b_data_1;
  logic       b_grant_0, b_grant_1, b_selector, b_out_valid;
  logic [1:0] b_data_out;

  int total;
  int bad;

  typedef struct {
    logic       rst;
    logic       r0;
    logic       r1;
    logic [1:0] d0;
    logic [1:0] d1;
    logic       g0;
    logic       g1;
    logic       sel;
    logic [1:0] dout;
    logic       v;
  } vec_t;

  vec_t vecs[$];

  mux2_rr_arbiter #(.WIDTH(2), .MAX_BURST(4)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .req_0    (req_0),
    .req_1    (req_1),
    .data_0   (data_0),
    .data_1   (data_1),
    .grant_0  (grant_0),
    .grant_1  (grant_1),
    .selector (selector),
    .data_out (data_out),
    .out_valid(out_valid)
  );

  mux2_rr_arbiter #(.WIDTH(2), .MAX_BURST(1)) u_dut_b1 (
    .clk      (clk),
    .reset    (b_reset),
    .req_0    (b_req_0),
    .req_1    (b_req_1),
    .data_0   (b_data_0),
    .data_1   (b_data_1),
    .grant_0  (b_grant_0),
    .grant_1  (b_grant_1),
    .selector (b_selector),
    .data_out (b_data_out),
    .out_valid(b_out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic r0, input logic r1,
                     input logic [1:0] d0, input logic [1:0] d1,
                     input logic g0, input logic g1, input logic sel,
                     input logic [1:0] dout, input logic v);
    vec_t e;
    e.rst = rst; e.r0 = r0; e.r1 = r1; e.d0 = d0; e.d1 = d1;
    e.g0 = g0; e.g1 = g1; e.sel = sel; e.dout = dout; e.v = v;
    vecs.push_back(e);
  endtask

  initial begin
    logic rr;
    logic eg1;
    logic [1:0] ed;
`ifdef MUX2_ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    total = 0;
    bad   = 0;
    reset = 1'b1; req_0 = 1'b0; req_1 = 1'b0; data_0 = 2'b00; data_1 = 2'b00;
    b_reset = 1'b1; b_req_0 = 1'b0; b_req_1 = 1'b0; b_data_0 = 2'b01; b_data_1 = 2'b10;

    //   rst r0 r1 d0     d1     g0 g1 sel dout   v
    add(1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0);   // reset state
    add(0, 1, 0, 2'b01, 2'b00, 1, 0, 0, 2'b00, 0);   // single requester 0
    add(0, 1, 0, 2'b01, 2'b00, 1, 0, 0, 2'b01, 1);
    add(0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 2'b01, 0);
    add(0, 0, 1, 2'b01, 2'b11, 0, 1, 1, 2'b01, 0);   // lone requester 1, burst wrap
    for (int k = 0; k < 9; k++) add(0, 0, 1, 2'b01, 2'b11, 0, 1, 1, 2'b11, 1);
    add(0, 1, 0, 2'b10, 2'b11, 1, 0, 0, 2'b11, 0);   // drop 1 -> grant 0
    add(0, 1, 1, 2'b10, 2'b01, 1, 0, 0, 2'b10, 1);
    add(0, 0, 1, 2'b10, 2'b01, 0, 1, 1, 2'b10, 0);   // drop 0 -> bubble
    add(0, 0, 1, 2'b10, 2'b01, 0, 1, 1, 2'b01, 1);
    add(0, 0, 1, 2'b10, 2'b01, 0, 1, 1, 2'b01, 1);   // burst_cnt now 2
    add(1, 1, 1, 2'b10, 2'b01, 0, 0, 0, 2'b00, 0);   // reset mid-burst
    add(0, 1, 1, 2'b10, 2'b11, 1, 0, 0, 2'b00, 0);   // tie after reset -> 0
    for (int k = 21; k <= 31; k++) begin
      eg1 = rr && (k >= 24) && (k <= 27);
      ed  = (rr && (k >= 25) && (k <= 28)) ? 2'b11 : 2'b10;
      add(0, 1, 1, 2'b10, 2'b11, ~eg1, eg1, eg1, ed, 1);
    end
    add(1, 0, 0, 2'b10, 2'b11, 0, 0, 0, 2'b00, 0);
    add(0, 0, 1, 2'b10, 2'b01, 0, 1, 1, 2'b00, 0);   // req 1 alone, then 0 joins
    add(0, 1, 1, 2'b10, 2'b01, 0, 1, 1, 2'b01, 1);
    add(0, 1, 1, 2'b10, 2'b01, 0, 1, 1, 2'b01, 1);
    add(0, 1, 1, 2'b10, 2'b01, 0, 1, 1, 2'b01, 1);
    add(0, 1, 1, 2'b10, 2'b01, 1, 0, 0, 2'b01, 1);   // 4th transfer, preempted
    add(0, 1, 0, 2'b10, 2'b01, 1, 0, 0, 2'b10, 1);
    add(0, 0, 0, 2'b10, 2'b01, 0, 0, 0, 2'b10, 0);
    add(0, 1, 1, 2'b10, 2'b01, ~rr, rr, rr, 2'b10, 0); // tie after last=0
    add(0, 0, 0, 2'b10, 2'b01, 0, 0, rr, 2'b10, 0);    // selector holds in IDLE

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; req_0 = vecs[i].r0; req_1 = vecs[i].r1;
      data_0 = vecs[i].d0; data_1 = vecs[i].d1;
      @(posedge clk);
      #1;
      total++;
      if ({grant_0, grant_1, selector, data_out, out_valid} !==
          {vecs[i].g0, vecs[i].g1, vecs[i].sel, vecs[i].dout, vecs[i].v}) begin
        bad++;
        $display("FAIL vec%0d: got g0=%b g1=%b sel=%b dout=%b v=%b, want g0=%b g1=%b sel=%b dout=%b v=%b",
                 i, grant_0, grant_1, selector, data_out, out_valid,
                 vecs[i].g0, vecs[i].g1, vecs[i].sel, vecs[i].dout, vecs[i].v);
      end
    end

    // MAX_BURST=1 with both requesting: alternation (round-robin) or grant 0 held.
    @(negedge clk);
    b_reset = 1'b1;
    @(negedge clk);
    b_reset = 1'b0; b_req_0 = 1'b1; b_req_1 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      eg1 = rr && (k >= 2) && (k % 2 == 0);
      if (k == 1) ed = 2'b00;
      else if (rr && (k % 2 == 1)) ed = 2'b10;
      else ed = 2'b01;
      total++;
      if ({b_grant_0, b_grant_1, b_data_out, b_out_valid} !== {~eg1, eg1, ed, (k >= 2)}) begin
        bad++;
        $display("FAIL burst1 edge%0d: got g0=%b g1=%b dout=%b v=%b, want g0=%b g1=%b dout=%b v=%b",
                 k, b_grant_0, b_grant_1, b_data_out, b_out_valid, ~eg1, eg1, ed, (k >= 2));
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
